// File: rtl/vfp_config_sequencer_pkg.sv
// Shared types for the vfpconfig programming sequencer.
//  vfp_cfg_state_e : sequencer FSM states
//  ERR_*           : err_code values reported on a failed entry
//  state_busy()    : true for every state that is part of an active table run
package vfp_config_sequencer_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StLatch,
      StWr,
      StBresp,
      StRd,
      StRresp,
      StNext,
      StDone,
      StError
   } vfp_cfg_state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_RESP     = 2'b01;
   localparam logic [1:0] ERR_MISMATCH = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   function automatic logic state_busy(input vfp_cfg_state_e s);
      return !(s inside {StIdle, StDone, StError});
   endfunction

endpackage

// File: rtl/vfp_config_sequencer_timeout_cnt.sv
// Per-state watchdog for the AXI phases of the sequencer.
//  clk, rst_n : clock, asynchronous active-low reset
//  restart    : high in the first cycle of a new state; that cycle counts as cycle 1
//  en         : current state is a timed AXI phase
//  expired    : the current state has now lasted TIMEOUT cycles
module vfp_config_sequencer_timeout_cnt #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // cnt holds the number of completed cycles in the state; saturates at LAST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= CW'(1);
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

   // The count is stale during the entry cycle, so restart masks it
   assign expired = en && !restart && (cnt >= LAST);

endmodule

// File: rtl/vfp_config_sequencer.sv
// AXI4-Lite master that writes an (addr,data) table into the VFP vfpconfig register bank,
// optionally reads each register back, then raises ready_to_read for the image source.
// A reconfig_req taken in DONE is deferred until the next frame_eof.
//  vfpconfig_aclk/aresetn       : clock, asynchronous active-low reset
//  start, reconfig_req          : run table now / at next frame_eof
//  frame_eof                    : end-of-frame strobe
//  tbl_idx -> tbl_addr/data/last: combinational table lookup
//  aw*/w*/b*/ar*/r*             : AXI4-Lite master to vfpconfig
//  busy, ready_to_read          : run in progress / table applied
//  err, err_code, err_idx       : sticky error with cause and failing entry
module vfp_config_sequencer
   import vfp_config_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MAX_ENTRIES = 64,
   parameter bit          VERIFY_EN   = 1'b1,
   parameter int unsigned TIMEOUT     = 1024,
   localparam int unsigned IDX_W      = $clog2(MAX_ENTRIES)
) (
   input  logic                      vfpconfig_aclk,
   input  logic                      vfpconfig_aresetn,
   input  logic                      start,
   input  logic                      reconfig_req,
   input  logic                      frame_eof,
   output logic [IDX_W-1:0]          tbl_idx,
   input  logic [ADDR_WIDTH-1:0]     tbl_addr,
   input  logic [DATA_WIDTH-1:0]     tbl_data,
   input  logic                      tbl_last,
   output logic [ADDR_WIDTH-1:0]     awaddr,
   output logic [2:0]                awprot,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH/8-1:0]   wstrb,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   output logic [ADDR_WIDTH-1:0]     araddr,
   output logic [2:0]                arprot,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [DATA_WIDTH-1:0]     rdata,
   input  logic [1:0]                rresp,
   input  logic                      rvalid,
   output logic                      rready,
   output logic                      busy,
   output logic                      ready_to_read,
   output logic                      err,
   output logic [1:0]                err_code,
   output logic [IDX_W-1:0]          err_idx
);

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_ENTRIES - 1);

   vfp_cfg_state_e state, state_prev;
   logic           aw_done, w_done, lat_last, pending;
   logic           tmo, timed;
   logic [1:0]     fail;

   assign awprot        = 3'b000;
   assign arprot        = 3'b000;
   assign wstrb         = '1;
   assign busy          = state_busy(state);
   assign ready_to_read = (state == StDone);
   assign timed         = state inside {StWr, StBresp, StRd, StRresp};

   vfp_config_sequencer_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk     (vfpconfig_aclk),
      .rst_n   (vfpconfig_aresetn),
      .restart (state != state_prev),
      .en      (timed),
      .expired (tmo)
   );

   // Failure cause this cycle; a response in hand takes precedence over the watchdog.
   // wdata still holds the value written for the current entry, so it is the readback reference.
   always_comb begin
      fail = ERR_NONE;
      case (state)
         StWr, StRd: if (tmo) fail = ERR_TIMEOUT;
         StBresp: begin
            if (bvalid) fail = (bresp != 2'b00) ? ERR_RESP : ERR_NONE;
            else if (tmo) fail = ERR_TIMEOUT;
         end
         StRresp: begin
            if (rvalid) begin
               if (rresp != 2'b00) fail = ERR_RESP;
               else if (rdata != wdata) fail = ERR_MISMATCH;
            end else if (tmo) begin
               fail = ERR_TIMEOUT;
            end
         end
         default: fail = ERR_NONE;
      endcase
   end

   always_ff @(posedge vfpconfig_aclk or negedge vfpconfig_aresetn) begin
      if (!vfpconfig_aresetn) begin
         state      <= StIdle;
         state_prev <= StIdle;
         tbl_idx    <= '0;
         awaddr     <= '0;
         wdata      <= '0;
         araddr     <= '0;
         awvalid    <= 1'b0;
         wvalid     <= 1'b0;
         bready     <= 1'b0;
         arvalid    <= 1'b0;
         rready     <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         lat_last   <= 1'b0;
         pending    <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
         err_idx    <= '0;
      end else begin
         state_prev <= state;
         if (fail != ERR_NONE) begin
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            err      <= 1'b1;
            err_code <= fail;
            err_idx  <= tbl_idx;
            state    <= StError;
         end else begin
            case (state)
               StIdle, StError, StDone: begin
                  if (start) begin
                     tbl_idx  <= '0;
                     err      <= 1'b0;
                     err_code <= ERR_NONE;
                     err_idx  <= '0;
                     pending  <= 1'b0;
                     state    <= StLatch;
                  end else if (state == StDone) begin
                     // A request arriving with the eof that would apply it waits for the next eof
                     if (frame_eof && pending) begin
                        pending <= 1'b0;
                        tbl_idx <= '0;
                        state   <= StLatch;
                     end else if (reconfig_req) begin
                        pending <= 1'b1;
                     end
                  end
               end
               StLatch: begin
                  awaddr   <= tbl_addr;
                  wdata    <= tbl_data;
                  lat_last <= tbl_last || (tbl_idx == IDX_MAX);
                  awvalid  <= 1'b1;
                  wvalid   <= 1'b1;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
                  state    <= StWr;
               end
               StWr: begin
                  if (aw_done && w_done) begin
                     bready <= 1'b1;
                     state  <= StBresp;
                  end else begin
                     if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                     end
                     if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                     end
                  end
               end
               StBresp: begin
                  if (bvalid) begin
                     bready <= 1'b0;
                     if (VERIFY_EN) begin
                        araddr  <= awaddr;
                        arvalid <= 1'b1;
                        state   <= StRd;
                     end else begin
                        state <= StNext;
                     end
                  end
               end
               StRd: begin
                  if (arready) begin
                     arvalid <= 1'b0;
                     rready  <= 1'b1;
                     state   <= StRresp;
                  end
               end
               StRresp: begin
                  if (rvalid) begin
                     rready <= 1'b0;
                     state  <= StNext;
                  end
               end
               StNext: begin
                  if (lat_last) begin
                     state <= StDone;
                  end else begin
                     tbl_idx <= tbl_idx + 1'b1;
                     state   <= StLatch;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule
